imem_arbiter: RTL and testbench

- Owns the single port of the synchronous instruction memory and shares it between two requesters: the core fetch unit (read) and the program loader (write, e.g. UART boot path).
- Sequences the system through a BOOT phase, where the loader fills memory and fetch is stalled, and a RUN phase, where fetch and late loader writes (debug patching) are round-robin arbitrated.
- Sits between the core's fetch stage and the instruction RAM.

---
 rtl/imem_pkg.sv | 29 ++
 rtl/imem_rr_arb.sv | 40 ++++
 rtl/imem_arbiter.sv | 118 +++++++++++
 tb/tb_imem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and address check for the instruction memory arbiter
package imem_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_LOAD  = 1'b1
    } grant_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic in_range;
        logic misaligned;
    } addr_chk_t;

    // Out-of-range means any bit above the word index is set.
    function automatic addr_chk_t check_addr(input logic [31:0] addr, input int unsigned idx_w);
        addr_chk_t r;
        r.in_range   = ((addr >> (idx_w + 2)) == 32'd0);
        r.misaligned = (addr[1:0] != 2'b00);
        return r;
    endfunction

endpackage

// File: rtl/imem_rr_arb.sv
// rtl/imem_rr_arb.sv - two-requester round-robin arbiter with a last-grant pointer
module imem_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_fetch,
    input  logic req_load,
    output logic gnt_fetch,
    output logic gnt_load
);
    import imem_pkg::*;

    grant_t last_q;

    always_comb begin
        gnt_fetch = 1'b0;
        gnt_load  = 1'b0;
        if (en) begin
            if (req_fetch && req_load) begin
                if (last_q == GNT_FETCH) gnt_load = 1'b1;
                else                     gnt_fetch = 1'b1;
            end else begin
                gnt_fetch = req_fetch;
                gnt_load  = req_load;
            end
        end
    end

    // Reset to FETCH so the loader wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_FETCH;
        end else if (gnt_load) begin
            last_q <= GNT_LOAD;
        end else if (gnt_fetch) begin
            last_q <= GNT_FETCH;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction memory port sharing between fetch and loader; IMEM_PRELOAD_EN starts in RUN
module imem_arbiter #(
    parameter int          IDX_W     = 11,
    parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_valid,
    output logic             f_ready,
    input  logic [31:0]      f_addr,
    output logic             f_rsp_valid,
    output logic [31:0]      f_rsp_data,
    input  logic             l_valid,
    output logic             l_ready,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    input  logic             l_last,
    output logic             m_en,
    output logic             m_we,
    output logic [IDX_W-1:0] m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata,
    output logic             run,
    output logic [CNT_W-1:0] boot_words,
    output logic             addr_err
);
    import imem_pkg::*;

`ifdef IMEM_PRELOAD_EN
    localparam state_t RESET_STATE = RUN;
`else
    localparam state_t RESET_STATE = BOOT;
`endif

    state_t           state_q;
    logic             f_rsp_valid_q;
    logic             oor_q;
    logic             addr_err_q;
    logic [CNT_W-1:0] boot_words_q;

    addr_chk_t f_chk;
    addr_chk_t l_chk;
    logic      arb_en;
    logic      gnt_fetch;
    logic      gnt_load;
    logic      f_acc;
    logic      l_acc;

    assign f_chk  = check_addr(f_addr, IDX_W);
    assign l_chk  = check_addr(l_addr, IDX_W);
    assign arb_en = rst_n && (state_q == RUN);

    imem_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (arb_en),
        .req_fetch (f_valid),
        .req_load  (l_valid),
        .gnt_fetch (gnt_fetch),
        .gnt_load  (gnt_load)
    );

    // Readies are held low while reset is asserted.
    always_comb begin
        f_ready = 1'b0;
        l_ready = 1'b0;
        if (rst_n) begin
            if (state_q == BOOT) begin
                l_ready = 1'b1;
            end else begin
                f_ready = gnt_fetch;
                l_ready = gnt_load;
            end
        end
    end

    assign f_acc = f_valid && f_ready;
    assign l_acc = l_valid && l_ready;

    // The arbiter guarantees at most one of f_acc/l_acc per cycle.
    assign m_en    = (l_acc && l_chk.in_range) || (f_acc && f_chk.in_range);
    assign m_we    = l_acc && l_chk.in_range;
    assign m_addr  = l_acc ? l_addr[IDX_W+1:2] : f_addr[IDX_W+1:2];
    assign m_wdata = l_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESET_STATE;
            f_rsp_valid_q <= 1'b0;
            oor_q         <= 1'b0;
            addr_err_q    <= 1'b0;
            boot_words_q  <= '0;
        end else begin
            f_rsp_valid_q <= f_acc;
            oor_q         <= f_acc && !f_chk.in_range;
            if ((f_acc && (f_chk.misaligned || !f_chk.in_range)) ||
                (l_acc && (l_chk.misaligned || !l_chk.in_range))) begin
                addr_err_q <= 1'b1;
            end
            if (state_q == BOOT && l_acc) begin
                if (boot_words_q != '1) begin
                    boot_words_q <= boot_words_q + 1'b1;
                end
                if (l_last) begin
                    state_q <= RUN;
                end
            end
        end
    end

    assign f_rsp_valid = f_rsp_valid_q;
    assign f_rsp_data  = oor_q ? NOP_INSTR : m_rdata;
    assign run         = (state_q == RUN);
    assign boot_words  = boot_words_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_addr;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_data;
    logic        l_valid;
    logic        l_ready;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_last;
    logic        m_en;
    logic        m_we;
    logic [10:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        run;
    logic [15:0] boot_words;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:2047];

    imem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_valid     (f_valid),
        .f_ready     (f_ready),
        .f_addr      (f_addr),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .l_valid     (l_valid),
        .l_ready     (l_ready),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_last      (l_last),
        .m_en        (m_en),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .run         (run),
        .boot_words  (boot_words),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM behind the arbiter.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

`ifdef IMEM_PRELOAD_EN
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h1000_0000 + i;
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        f_valid = 1'b0;
        f_addr  = 32'h0;
        l_valid = 1'b0;
        l_addr  = 32'h0;
        l_wdata = 32'h0;
        l_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_f_rsp_valid", f_rsp_valid, 0);
        check("rst_f_ready", f_ready, 0);
        check("rst_l_ready", l_ready, 0);
        check("rst_m_en", m_en, 0);
        check("rst_m_we", m_we, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_boot_words", boot_words, 0);
        #3 rst_n = 1'b1;
        #1;
`ifdef IMEM_PRELOAD_EN
        check("pre_run", run, 1);
        f_valid = 1'b1;
        f_addr  = 32'h0;
        #1;
        check("pre_f_ready", f_ready, 1);
        check("pre_m_en", m_en, 1);
        check("pre_m_addr", m_addr, 0);
        tick();
        f_valid = 1'b0;
        check("pre_rsp_valid", f_rsp_valid, 1);
        check("pre_rsp_data", f_rsp_data, 32'h1000_0000);
        check("pre_boot_words", boot_words, 0);
`else
        check("boot_run", run, 0);
        check("boot_l_ready_idle", l_ready, 1);

        // Boot load with fetch held pending.
        f_valid = 1'b1;
        f_addr  = 32'h8;
        for (int i = 0; i < 4; i++) begin
            l_valid = 1'b1;
            l_addr  = 32'(i * 4);
            l_wdata = 32'hA0 + 32'(i);
            l_last  = (i == 3);
            #1;
            check("boot_f_ready", f_ready, 0);
            check("boot_l_ready", l_ready, 1);
            check("boot_m_en", m_en, 1);
            check("boot_m_we", m_we, 1);
            check("boot_m_addr", m_addr, 32'(i));
            check("boot_run_low", run, 0);
            tick();
        end
        l_valid = 1'b0;
        l_last  = 1'b0;
        check("boot_run_high", run, 1);
        check("boot_words_4", boot_words, 4);
        #1;
        check("first_f_ready", f_ready, 1);
        check("first_m_we", m_we, 0);
        check("first_m_addr", m_addr, 2);
        tick();
        check("first_rsp_valid", f_rsp_valid, 1);
        check("first_rsp_data", f_rsp_data, 32'hA2);

        // Streaming fetch: one response per cycle.
        for (int k = 0; k < 3; k++) begin
            f_addr = 32'(k * 4);
            #1;
            check("stream_f_ready", f_ready, 1);
            tick();
            check("stream_rsp_valid", f_rsp_valid, 1);
            check("stream_rsp_data", f_rsp_data, 32'hA0 + 32'(k));
        end
        f_valid = 1'b0;
        tick();
        check("stream_rsp_idle", f_rsp_valid, 0);

        // Contention after a FETCH grant: LOAD, FETCH, LOAD, FETCH.
        f_valid = 1'b1;
        f_addr  = 32'h4;
        l_valid = 1'b1;
        l_last  = 1'b1;
        l_addr  = 32'h10;
        l_wdata = 32'hB0;
        #1;
        check("cont0_l_ready", l_ready, 1);
        check("cont0_f_ready", f_ready, 0);
        check("cont0_m_addr", m_addr, 4);
        tick();
        l_addr  = 32'h14;
        l_wdata = 32'hB1;
        #1;
        check("cont1_f_ready", f_ready, 1);
        check("cont1_l_ready", l_ready, 0);
        tick();
        check("cont1_rsp_data", f_rsp_data, 32'hA1);
        #1;
        check("cont2_l_ready", l_ready, 1);
        check("cont2_f_ready", f_ready, 0);
        check("cont2_m_addr", m_addr, 5);
        tick();
        check("cont2_rsp_valid", f_rsp_valid, 0);
        l_addr  = 32'h18;
        l_wdata = 32'hB2;
        #1;
        check("cont3_f_ready", f_ready, 1);
        check("cont3_l_ready", l_ready, 0);
        tick();
        check("cont3_rsp_data", f_rsp_data, 32'hA1);
        f_valid = 1'b0;
        #1;
        check("cont4_l_ready", l_ready, 1);
        tick();
        l_valid = 1'b0;
        l_last  = 1'b0;
        check("cont_run_kept", run, 1);
        check("cont_boot_words", boot_words, 4);

        // Loader writes from contention are readable.
        f_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            f_addr = 32'h10 + 32'(k * 4);
            tick();
            check("patch_rsp_data", f_rsp_data, 32'hB0 + 32'(k));
        end
        check("no_err_yet", addr_err, 0);

        // Out-of-range and misaligned fetches.
        f_addr = 32'h2000;
        #1;
        check("oor_f_ready", f_ready, 1);
        check("oor_m_en", m_en, 0);
        tick();
        check("oor_rsp_valid", f_rsp_valid, 1);
        check("oor_rsp_data", f_rsp_data, 32'h13);
        check("oor_addr_err", addr_err, 1);
        f_addr = 32'h6;
        #1;
        check("mis_m_en", m_en, 1);
        check("mis_m_addr", m_addr, 1);
        tick();
        check("mis_rsp_data", f_rsp_data, 32'hA1);
        check("mis_addr_err", addr_err, 1);
        f_valid = 1'b0;
        l_valid = 1'b1;
        l_addr  = 32'h8000_0000;
        #1;
        check("oorw_l_ready", l_ready, 1);
        check("oorw_m_en", m_en, 0);
        tick();
        l_valid = 1'b0;

        // Reset in the cycle after a fetch accept.
        f_valid = 1'b1;
        f_addr  = 32'h0;
        tick();
        check("mid_rsp_before", f_rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rsp_cleared", f_rsp_valid, 0);
        check("mid_run", run, 0);
        check("mid_boot_words", boot_words, 0);
        check("mid_addr_err", addr_err, 0);
        check("mid_l_ready", l_ready, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        f_addr = 32'h10;
        #1;
        check("reboot_run", run, 0);
        check("reboot_l_ready", l_ready, 1);
        check("reboot_f_ready", f_ready, 0);
        l_valid = 1'b1;
        l_addr  = 32'h20;
        l_wdata = 32'hC0;
        l_last  = 1'b1;
        tick();
        l_valid = 1'b0;
        l_last  = 1'b0;
        check("reboot_run_high", run, 1);
        check("reboot_words", boot_words, 1);
        #1;
        check("reboot_f_ready_run", f_ready, 1);
        tick();
        check("reboot_mem_kept", f_rsp_data, 32'hB0);
        f_valid = 1'b0;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
